// File: rtl/mc_controller.sv
// Multi-cycle MIPS-subset control FSM (IF/ID/EX/MEM/WB) driving datapath strobes.
// Optional retired-instruction counter enabled by defining MC_RETIRE_CNT_EN.
module mc_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        zero,
    output logic        IR_in,
    output logic        IR_out,
    output logic        PC_in,
    output logic        imem_re,
    output logic        dmem_re,
    output logic        dmem_we,
    output logic        reg_we,
    output logic [1:0]  pc_src,
    output logic [1:0]  reg_dst,
    output logic [3:0]  alu_op,
    output logic        alu_src_b,
    output logic        mem_to_reg,
`ifdef MC_RETIRE_CNT_EN
    output logic [31:0] retire_cnt,
`endif
    output logic [2:0]  state
);

    localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4;

    localparam logic [3:0] C_NOP = 4'd0, C_RALU = 4'd1, C_IALU = 4'd2, C_LW = 4'd3, C_SW = 4'd4,
                           C_BEQ = 4'd5, C_BNE = 4'd6, C_J = 4'd7, C_JAL = 4'd8, C_JR = 4'd9;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                           ALU_SLT = 4'd4, ALU_SLL = 4'd5, ALU_LUI = 4'd6;

    logic [2:0] state_q, state_d;
    logic [3:0] cls;
    logic [3:0] alu_fn;
    logic       instr_unused;

    assign instr_unused = ^instr[25:6];
    assign state        = state_q;

    always_comb begin
        cls    = C_NOP;
        alu_fn = ALU_ADD;
        case (instr[31:26])
            6'h00: begin
                case (instr[5:0])
                    6'h21: begin cls = C_RALU; alu_fn = ALU_ADD; end
                    6'h23: begin cls = C_RALU; alu_fn = ALU_SUB; end
                    6'h24: begin cls = C_RALU; alu_fn = ALU_AND; end
                    6'h25: begin cls = C_RALU; alu_fn = ALU_OR;  end
                    6'h2A: begin cls = C_RALU; alu_fn = ALU_SLT; end
                    6'h00: begin cls = C_RALU; alu_fn = ALU_SLL; end
                    6'h08: cls = C_JR;
                    default: cls = C_NOP;
                endcase
            end
            6'h09: begin cls = C_IALU; alu_fn = ALU_ADD; end
            6'h0C: begin cls = C_IALU; alu_fn = ALU_AND; end
            6'h0D: begin cls = C_IALU; alu_fn = ALU_OR;  end
            6'h0F: begin cls = C_IALU; alu_fn = ALU_LUI; end
            6'h23: cls = C_LW;
            6'h2B: cls = C_SW;
            6'h04: begin cls = C_BEQ; alu_fn = ALU_SUB; end
            6'h05: begin cls = C_BNE; alu_fn = ALU_SUB; end
            6'h02: cls = C_J;
            6'h03: cls = C_JAL;
            default: cls = C_NOP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IF;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:  state_d = imem_ready ? S_ID : S_IF;
            S_ID: begin
                case (cls)
                    C_RALU, C_IALU, C_LW, C_SW, C_BEQ, C_BNE, C_JR: state_d = S_EX;
                    C_JAL:   state_d = S_WB;
                    default: state_d = S_IF;
                endcase
            end
            S_EX: begin
                case (cls)
                    C_RALU, C_IALU: state_d = S_WB;
                    C_LW, C_SW:     state_d = S_MEM;
                    default:        state_d = S_IF;
                endcase
            end
            S_MEM: begin
                if (!dmem_ready)      state_d = S_MEM;
                else if (cls == C_LW) state_d = S_WB;
                else                  state_d = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

    // Outputs are gated by rst so a pending access or write drops the instant reset rises.
    always_comb begin
        IR_in      = 1'b0;
        IR_out     = 1'b0;
        PC_in      = 1'b0;
        imem_re    = 1'b0;
        dmem_re    = 1'b0;
        dmem_we    = 1'b0;
        reg_we     = 1'b0;
        pc_src     = 2'd0;
        reg_dst    = 2'd0;
        alu_op     = ALU_ADD;
        alu_src_b  = 1'b0;
        mem_to_reg = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IF: begin
                    imem_re = 1'b1;
                    IR_in   = imem_ready;
                    PC_in   = imem_ready;
                end
                S_ID: begin
                    IR_out = 1'b1;
                    if (cls == C_J || cls == C_JAL) begin
                        PC_in  = 1'b1;
                        pc_src = 2'd2;
                    end
                end
                S_EX: begin
                    IR_out    = 1'b1;
                    alu_op    = alu_fn;
                    alu_src_b = (cls == C_IALU) || (cls == C_LW) || (cls == C_SW);
                    if ((cls == C_BEQ && zero) || (cls == C_BNE && !zero)) begin
                        PC_in  = 1'b1;
                        pc_src = 2'd1;
                    end else if (cls == C_JR) begin
                        PC_in  = 1'b1;
                        pc_src = 2'd3;
                    end
                end
                S_MEM: begin
                    IR_out  = 1'b1;
                    dmem_re = (cls == C_LW);
                    dmem_we = (cls == C_SW);
                end
                S_WB: begin
                    IR_out = 1'b1;
                    reg_we = 1'b1;
                    case (cls)
                        C_RALU:  reg_dst = 2'd1;
                        C_JAL:   reg_dst = 2'd2;
                        default: reg_dst = 2'd0;
                    endcase
                    mem_to_reg = (cls == C_LW);
                end
                default: ;
            endcase
        end
    end

`ifdef MC_RETIRE_CNT_EN
    logic [31:0] retire_cnt_q, retire_cnt_d;

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (state_d == S_IF && (state_q == S_ID || state_q == S_EX ||
                                state_q == S_MEM || state_q == S_WB))
            retire_cnt_d = retire_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) retire_cnt_q <= 32'd0;
        else     retire_cnt_q <= retire_cnt_d;
    end

    assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-cycle expected output vectors are queued
// as stimulus is applied and popped/compared when the outputs are sampled.
module tb_mc_controller;

    logic        clk, rst;
    logic [31:0] instr;
    logic        imem_ready, dmem_ready, zero;
    logic        IR_in, IR_out, PC_in, imem_re, dmem_re, dmem_we, reg_we;
    logic [1:0]  pc_src, reg_dst;
    logic [3:0]  alu_op;
    logic        alu_src_b, mem_to_reg;
    logic [2:0]  state;
`ifdef MC_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ir;
        logic        dr;
        logic        z;
        logic [19:0] e;
    } step_t;

    logic [19:0] sb[$];

    // strobe order: IR_in, IR_out, PC_in, imem_re, dmem_re, dmem_we, reg_we
    localparam logic [6:0] B_NONE = 7'b0000000, B_IFR = 7'b1011000, B_IFW = 7'b0001000,
                           B_OUT = 7'b0100000, B_PC = 7'b0110000, B_RD = 7'b0100100,
                           B_WR = 7'b0100010, B_WE = 7'b0100001;
    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_OR = 4'd3;

    localparam logic [31:0] I_ADDU = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
    localparam logic [31:0] I_ORI  = {6'h0D, 5'd1, 5'd4, 16'h00FF};
    localparam logic [31:0] I_LW   = {6'h23, 5'd1, 5'd5, 16'h0010};
    localparam logic [31:0] I_SW   = {6'h2B, 5'd1, 5'd5, 16'h0020};
    localparam logic [31:0] I_BEQ  = {6'h04, 5'd1, 5'd2, 16'h0004};
    localparam logic [31:0] I_BNE  = {6'h05, 5'd1, 5'd2, 16'h0004};
    localparam logic [31:0] I_JAL  = {6'h03, 26'h0000100};
    localparam logic [31:0] I_J    = {6'h02, 26'h0000200};
    localparam logic [31:0] I_JR   = {6'h00, 5'd31, 15'd0, 6'h08};
    localparam logic [31:0] I_BAD  = {6'h3F, 26'd0};

    mc_controller dut (
        .clk(clk), .rst(rst), .instr(instr), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .zero(zero), .IR_in(IR_in), .IR_out(IR_out),
        .PC_in(PC_in), .imem_re(imem_re), .dmem_re(dmem_re), .dmem_we(dmem_we),
        .reg_we(reg_we), .pc_src(pc_src), .reg_dst(reg_dst), .alu_op(alu_op),
        .alu_src_b(alu_src_b), .mem_to_reg(mem_to_reg),
`ifdef MC_RETIRE_CNT_EN
        .retire_cnt(retire_cnt),
`endif
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [19:0] ev(input logic [2:0] s, input logic [6:0] b,
                                       input logic [1:0] ps, input logic [1:0] rd,
                                       input logic [3:0] aop, input logic asb, input logic m2r);
        return {s, b, ps, rd, aop, asb, m2r};
    endfunction

    function automatic logic [19:0] obs();
        return {state, IR_in, IR_out, PC_in, imem_re, dmem_re, dmem_we, reg_we,
                pc_src, reg_dst, alu_op, alu_src_b, mem_to_reg};
    endfunction

    task automatic apply(input step_t s);
        imem_ready = s.ir;
        dmem_ready = s.dr;
        zero       = s.z;
        sb.push_back(s.e);
    endtask

    task automatic test_reset();
        step_t st[$];
        logic [19:0] exp_v, got;
        instr = I_ADDU; imem_ready = 1'b1; dmem_ready = 1'b1; zero = 1'b0;
        rst = 1'b1;
        sb.push_back(ev(3'd0, B_NONE, 2'd0, 2'd0, A_ADD, 1'b0, 1'b0));
        @(posedge clk); #1;
        exp_v = sb.pop_front(); got = obs();
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL reset_hold got %h want %h", got, exp_v);
        end
        rst = 1'b0;
        st.push_back('{1'b0, 1'b0, 1'b0, ev(3'd0, B_IFW, 2'd0, 2'd0, A_ADD, 1'b0, 1'b0)});
        st.push_back('{1'b0, 1'b0, 1'b0, ev(3'd0, B_IFW, 2'd0, 2'd0, A_ADD, 1'b0, 1'b0)});
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge clk);
            exp_v = sb.pop_front(); got = obs();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL reset_ifwait cyc %0d got %h want %h", i, got, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu();
        step_t st[$];
        logic [19:0] exp_v, got;
        st.push_back('{1'b1, 1'b0, 1'b0, ev(3'd0, B_IFR, 2'd0, 2'd0, A_ADD, 1'b0, 1'b0)});
        st.push_back('{1'b1, 1'b0, 1'b0, ev(3'd1, B_OUT, 2'd0, 2'd0, A_ADD, 1'b0, 1'b0)});
        st.push_back('{1'b1, 1'b0, 1'b0, ev(3'd2, B_OUT, 2'd0, 2'd0, A_ADD, 1'b0, 1'b0)});
        st.push_back('{1'b1, 1'b0, 1'b0, ev(3'd4, B_WE,  2'd0, 2'd1, A_ADD, 1'b0, 1'b0)});
        st.push_back('{1'b1, 1'b0, 1'b0, ev(3'd0, B_IFR, 2'd0, 2'd0, A_ADD, 1'b0, 1'b0)});
        st.push_back('{1'b1, 1'b0, 1'b0, ev(3'd1, B_OUT, 2'd0, 2'd0, A_ADD, 1'b0, 1'b0)});
        st.push_back('{1'b1, 1'b0, 1'b0, ev(3'd2, B_OUT, 2'd0, 2'd0, A_OR,  1'b1, 1'b0)});
        st.push_back('{1'b1, 1'b0, 1'b0, ev(3'd4, B_WE,  2'd0, 2'd0, A_ADD, 1'b0, 1'b0)});
        foreach (st[i]) begin
            instr = (i < 4) ? I_ADDU : I_ORI;
            apply(st[i]);
            @(negedge clk);
            exp_v = sb.pop_front(); got = obs();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL alu cyc %0d got %h want %h", i, got, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_wait();
        step_t st[$];
        logic [19:0] exp_v, got;
        instr = I_LW;
        st.push_back('{1'b1, 1'b0, 1'b0, ev(3'd0, B_IFR, 2'd0, 2'd0, A_ADD, 1'b0, 1'b0)});
        st.push_back('{1'b1, 1'b0, 1'b0, ev(3'd1, B_OUT, 2'd0, 2'd0, A_ADD, 1'b0, 1'b0)});
        st.push_back('{1'b1, 1'b0, 1'b0, ev(3'd2, B_OUT, 2'd0, 2'd0, A_ADD, 1'b1, 1'b0)});
        for (int k = 0; k < 3; k++)
            st.push_back('{1'b1, 1'b0, 1'b0, ev(3'd3, B_RD, 2'd0, 2'd0, A_ADD, 1'b0, 1'b0)});
        st.push_back('{1'b1, 1'b1, 1'b0, ev(3'd3, B_RD, 2'd0, 2'd0, A_ADD, 1'b0, 1'b0)});
        st.push_back('{1'b1, 1'b0, 1'b0, ev(3'd4, B_WE, 2'd0, 2'd0, A_ADD, 1'b0, 1'b1)});
        st.push_back('{1'b1, 1'b0, 1'b0, ev(3'd0, B_IFR, 2'd0, 2'd0, A_ADD, 1'b0, 1'b0)});
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge clk);
            exp_v = sb.pop_front(); got = obs();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL lw_wait cyc %0d got %h want %h", i, got, exp_v);
            end
            if (i < 8) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_branch();
        step_t st[$];
        logic [19:0] exp_v, got;
        // beq taken, bne not taken (zero=1), bne taken (zero=0)
        st.push_back('{1'b1, 1'b0, 1'b1, ev(3'd1, B_OUT, 2'd0, 2'd0, A_ADD, 1'b0, 1'b0)});
        st.push_back('{1'b1, 1'b0, 1'b1, ev(3'd2, B_PC,  2'd1, 2'd0, A_SUB, 1'b0, 1'b0)});
        st.push_back('{1'b1, 1'b0, 1'b1, ev(3'd0, B_IFR, 2'd0, 2'd0, A_ADD, 1'b0, 1'b0)});
        st.push_back('{1'b1, 1'b0, 1'b1, ev(3'd1, B_OUT, 2'd0, 2'd0, A_ADD, 1'b0, 1'b0)});
        st.push_back('{1'b1, 1'b0, 1'b1, ev(3'd2, B_OUT, 2'd0, 2'd0, A_SUB, 1'b0, 1'b0)});
        st.push_back('{1'b1, 1'b0, 1'b0, ev(3'd0, B_IFR, 2'd0, 2'd0, A_ADD, 1'b0, 1'b0)});
        st.push_back('{1'b1, 1'b0, 1'b0, ev(3'd1, B_OUT, 2'd0, 2'd0, A_ADD, 1'b0, 1'b0)});
        st.push_back('{1'b1, 1'b0, 1'b0, ev(3'd2, B_PC,  2'd1, 2'd0, A_SUB, 1'b0, 1'b0)});
        st.push_back('{1'b1, 1'b0, 1'b0, ev(3'd0, B_IFR, 2'd0, 2'd0, A_ADD, 1'b0, 1'b0)});
        instr = I_BEQ;
        foreach (st[i]) begin
            if (i == 2) instr = I_BNE;
            apply(st[i]);
            @(negedge clk);
            exp_v = sb.pop_front(); got = obs();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL branch cyc %0d got %h want %h", i, got, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jumps();
        step_t st[$];
        logic [19:0] exp_v, got;
        st.push_back('{1'b1, 1'b0, 1'b0, ev(3'd1, B_PC,  2'd2, 2'd0, A_ADD, 1'b0, 1'b0)});
        st.push_back('{1'b1, 1'b0, 1'b0, ev(3'd4, B_WE,  2'd0, 2'd2, A_ADD, 1'b0, 1'b0)});
        st.push_back('{1'b1, 1'b0, 1'b0, ev(3'd0, B_IFR, 2'd0, 2'd0, A_ADD, 1'b0, 1'b0)});
        st.push_back('{1'b1, 1'b0, 1'b0, ev(3'd1, B_OUT, 2'd0, 2'd0, A_ADD, 1'b0, 1'b0)});
        st.push_back('{1'b1, 1'b0, 1'b0, ev(3'd2, B_PC,  2'd3, 2'd0, A_ADD, 1'b0, 1'b0)});
        st.push_back('{1'b1, 1'b0, 1'b0, ev(3'd0, B_IFR, 2'd0, 2'd0, A_ADD, 1'b0, 1'b0)});
        instr = I_JAL;
        foreach (st[i]) begin
            if (i == 2) instr = I_JR;
            apply(st[i]);
            @(negedge clk);
            exp_v = sb.pop_front(); got = obs();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL jumps cyc %0d got %h want %h", i, got, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_reset_nop();
        step_t st[$];
        logic [19:0] exp_v, got;
        st.push_back('{1'b1, 1'b0, 1'b0, ev(3'd1, B_OUT, 2'd0, 2'd0, A_ADD, 1'b0, 1'b0)});
        st.push_back('{1'b1, 1'b0, 1'b0, ev(3'd2, B_OUT, 2'd0, 2'd0, A_ADD, 1'b1, 1'b0)});
        st.push_back('{1'b1, 1'b0, 1'b0, ev(3'd3, B_WR,  2'd0, 2'd0, A_ADD, 1'b0, 1'b0)});
        instr = I_SW;
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge clk);
            exp_v = sb.pop_front(); got = obs();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL sw cyc %0d got %h want %h", i, got, exp_v);
            end
            @(posedge clk); #1;
        end
        #1;
        rst = 1'b1;
        sb.push_back(ev(3'd0, B_NONE, 2'd0, 2'd0, A_ADD, 1'b0, 1'b0));
        #1;
        exp_v = sb.pop_front(); got = obs();
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL sw_async_reset got %h want %h", got, exp_v);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        st.delete();
        st.push_back('{1'b1, 1'b0, 1'b0, ev(3'd0, B_IFR, 2'd0, 2'd0, A_ADD, 1'b0, 1'b0)});
        st.push_back('{1'b1, 1'b0, 1'b0, ev(3'd1, B_OUT, 2'd0, 2'd0, A_ADD, 1'b0, 1'b0)});
        st.push_back('{1'b1, 1'b0, 1'b0, ev(3'd0, B_IFR, 2'd0, 2'd0, A_ADD, 1'b0, 1'b0)});
        instr = I_BAD;
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge clk);
            exp_v = sb.pop_front(); got = obs();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL nop cyc %0d got %h want %h", i, got, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

`ifdef MC_RETIRE_CNT_EN
    task automatic test_retire();
        logic [31:0] exp_c;
        rst = 1'b1; #1; rst = 1'b0;
        instr = I_J; imem_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        exp_c = 32'd5;
        checks++;
        if (retire_cnt !== exp_c) begin
            errors++;
            $display("FAIL retire_five got %h want %h", retire_cnt, exp_c);
        end
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt_q;
        repeat (2) @(posedge clk);
        #1;
        exp_c = 32'd0;
        checks++;
        if (retire_cnt !== exp_c) begin
            errors++;
            $display("FAIL retire_wrap got %h want %h", retire_cnt, exp_c);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_lw_wait();
        test_branch();
        test_jumps();
        test_sw_reset_nop();
`ifdef MC_RETIRE_CNT_EN
        test_retire();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single system clock; all state updates occur on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port instr, input, 32 bits: current instruction from the instruction register output.
REQ-004 SHALL have ports imem_ready and dmem_ready, input, 1 bit each: memory access completes in this cycle.
REQ-005 SHALL have port zero, input, 1 bit: ALU result equals zero.
REQ-006 SHALL have ports IR_in, IR_out, PC_in, imem_re, dmem_re, dmem_we and reg_we, output, 1 bit each: load and enable strobes.
REQ-007 SHALL have output ports pc_src (2 bits: 0=PC+4, 1=branch, 2=jump, 3=rs) and reg_dst (2 bits: 0=rt, 1=rd, 2=$31).
REQ-008 SHALL have output ports alu_op (4 bits), alu_src_b (1 bit: 0=rt, 1=imm), mem_to_reg (1 bit) and state (3 bits: current state code).

Function
REQ-009 SHALL implement states IF=0, ID=1, EX=2, MEM=3, WB=4 in a 3-bit state register; other codes SHALL go to IF on the next edge.
REQ-010 SHALL, in IF, assert imem_re and hold until imem_ready=1; in that cycle assert IR_in and PC_in (pc_src=0), then go to ID.
REQ-011 SHALL assert IR_out in every state except IF.
REQ-012 SHALL support addu, subu, and, or, slt, sll, jr, addiu, andi, ori, lui, lw, sw, beq, bne, j and jal.
REQ-013 SHALL sequence R-type ALU ops and immediate ALU ops as IF-ID-EX-WB (4 cycles minimum); WB asserts reg_we, reg_dst=1 for R-type and 0 for immediate.
REQ-014 SHALL sequence lw as IF-ID-EX-MEM-WB: MEM asserts dmem_re and holds until dmem_ready; WB asserts reg_we with mem_to_reg=1.
REQ-015 SHALL sequence sw as IF-ID-EX-MEM: MEM asserts dmem_we and holds until dmem_ready, then returns to IF.
REQ-016 SHALL sequence beq/bne as IF-ID-EX: EX performs a subtract; PC_in=1 with pc_src=1 only when zero==1 (beq) or zero==0 (bne).
REQ-017 SHALL sequence j as IF-ID, with PC_in=1 and pc_src=2 in ID.
REQ-018 SHALL sequence jal as IF-ID-WB: ID writes the PC with pc_src=2; WB asserts reg_we with reg_dst=2.
REQ-019 SHALL sequence jr as IF-ID-EX, with PC_in=1 and pc_src=3 in EX.
REQ-020 SHALL treat an unsupported opcode or funct as a NOP: ID returns to IF and no write strobe is asserted.
REQ-021 SHALL drive outputs combinationally from the state register and instr; every strobe not listed for a state SHALL be 0.
REQ-022 SHALL never assert dmem_re and dmem_we in the same cycle, and SHALL never assert reg_we outside WB.

Reset
REQ-023 SHALL force the state to IF immediately when rst rises, independent of clk.
REQ-024 SHALL hold all 1-bit outputs at 0, and pc_src, reg_dst and alu_op at 0, while rst=1.
REQ-025 SHALL, on reset during MEM or WB, drop the pending access or write in the same cycle; after release, the first rising edge begins IF.

Configuration
REQ-026 SHALL, when macro MC_RETIRE_CNT_EN is defined, add output retire_cnt (32 bits), reset to 0.
REQ-027 SHALL increment retire_cnt by 1 on each rising edge that returns to IF from ID, EX, MEM or WB; it wraps from 0xFFFFFFFF to 0.
REQ-028 SHALL omit the retire_cnt port and its logic when MC_RETIRE_CNT_EN is undefined.

Verification
REQ-029 SHALL cover: reset, then imem_ready=1 every cycle, with addu $3,$1,$2 -> states 0,1,2,4,0; reg_we=1 with reg_dst=1 only in state 4.
REQ-030 SHALL cover: lw with dmem_ready low for 3 cycles -> MEM held for 4 cycles with dmem_re=1; WB then has mem_to_reg=1; 8 cycles total.
REQ-031 SHALL cover: beq with zero=1, then bne with zero=1 -> PC_in=1 with pc_src=1 in EX only for beq; each instruction takes 3 cycles.
REQ-032 SHALL cover: jal -> ID has PC_in=1 with pc_src=2; WB has reg_we=1 with reg_dst=2; 3 cycles.
REQ-033 SHALL cover: rst pulsed mid-MEM of sw -> dmem_we falls with rst, state=0; opcode 0x3F -> IF, ID, IF with no write strobes.
REQ-034 SHALL cover, with MC_RETIRE_CNT_EN defined: 5 instructions retired -> retire_cnt=5; preload at 0xFFFFFFFF, retire 1 instruction -> retire_cnt=0.
